// File: rtl/stream_to_video.sv
// stream_to_video: renders a packed 1-bpp byte stream as a black/white raster
// for a DVI encoder.
//   clk_i, rst_i  : single clock, synchronous active-high reset
//   ce_i          : pixel-advance enable from the encoder
//   s_dat_i       : 8 pixels per byte, MSB displayed first
//   s_sof_i       : marks the first byte of a frame
//   s_valid_i     : byte valid; s_ready_o accepts it (combinational from FIFO level)
//   de_o, pix_o   : registered data enable and pixel
//   frame_o       : one-cycle pulse after the ce_i cycle at col=0,row=0
//   underflow_o   : sticky, set when a byte was needed while the FIFO was empty
module stream_to_video #(
    parameter logic [9:0]  NumColTotal  = 10'd800,
    parameter logic [9:0]  NumColActive = 10'd640,
    parameter logic [9:0]  NumRowTotal  = 10'd525,
    parameter logic [9:0]  NumRowActive = 10'd480,
    parameter int unsigned FifoDepth    = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ce_i,
    input  logic [7:0] s_dat_i,
    input  logic       s_sof_i,
    input  logic       s_valid_i,
    output logic       s_ready_o,
    output logic       de_o,
    output logic       pix_o,
    output logic       frame_o,
    output logic       underflow_o
);

    localparam int unsigned AddrW = $clog2(FifoDepth);
    localparam int unsigned CntW  = AddrW + 1;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e state_q;
    state_e state_d;

    // Byte FIFO holding {sof, dat}
    logic [8:0]       mem [FifoDepth];
    logic [AddrW-1:0] wr_ptr;
    logic [AddrW-1:0] rd_ptr;
    logic [CntW-1:0]  count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             head_sof;
    logic [7:0]       head_dat;

    // Raster position
    logic [9:0] col;
    logic [9:0] row;
    logic       active;
    logic       origin;
    logic       fetch;

    // Pixel path control decided by the FSM
    logic       load;
    logic       kill;
    logic       set_uf;
    logic [6:0] shreg;

    assign full      = (count == CntW'(FifoDepth));
    assign empty     = (count == '0);
    assign s_ready_o = !full && !rst_i;
    assign push      = s_valid_i && s_ready_o;
    assign head_sof  = mem[rd_ptr][8];
    assign head_dat  = mem[rd_ptr][7:0];

    assign active = (col < NumColActive) && (row < NumRowActive);
    assign origin = (col == 10'd0) && (row == 10'd0);
    assign fetch  = ce_i && active && (col[2:0] == 3'd0);

    // FIFO storage; contents are don't-care once pointers are reset
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {s_sof_i, s_dat_i};
        end
    end

    // FIFO pointers and level
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AddrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AddrW'(1);
            end
            if (push && !pop) begin
                count <= count + CntW'(1);
            end else if (pop && !push) begin
                count <= count - CntW'(1);
            end
        end
    end

    // Column/row counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col <= '0;
            row <= '0;
        end else if (ce_i) begin
            if (col == NumColTotal - 10'd1) begin
                col <= '0;
                if (row == NumRowTotal - 10'd1) begin
                    row <= '0;
                end else begin
                    row <= row + 10'd1;
                end
            end else begin
                col <= col + 10'd1;
            end
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, FIFO pop and pixel-path control
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        load    = 1'b0;
        kill    = 1'b0;
        set_uf  = 1'b0;
        case (state_q)
            SYNC: begin
                // Discard bytes until a frame start is at the head
                if (!empty && !head_sof) begin
                    pop = 1'b1;
                end else if (fetch && origin && !empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (fetch) begin
                    if (empty) begin
                        set_uf  = 1'b1;
                        kill    = 1'b1;
                        state_d = SYNC;
                    end else if (head_sof != origin) begin
                        // Early sof is kept for the next frame; a missing sof is dropped
                        pop     = !head_sof;
                        kill    = 1'b1;
                        state_d = SYNC;
                    end else begin
                        pop  = 1'b1;
                        load = 1'b1;
                    end
                end
            end
            default: state_d = SYNC;
        endcase
    end

    // Registered video outputs and pixel shift register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            de_o        <= 1'b0;
            pix_o       <= 1'b0;
            frame_o     <= 1'b0;
            underflow_o <= 1'b0;
            shreg       <= '0;
        end else begin
            if (set_uf) begin
                underflow_o <= 1'b1;
            end
            if (ce_i) begin
                de_o    <= active;
                frame_o <= origin;
                if (load) begin
                    pix_o <= head_dat[7];
                    shreg <= head_dat[6:0];
                end else if (active && !fetch && (state_q == RUN)) begin
                    pix_o <= shreg[6];
                    shreg <= {shreg[5:0], 1'b0};
                end else begin
                    pix_o <= 1'b0;
                    if (kill) begin
                        shreg <= '0;
                    end
                end
            end else begin
                frame_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_to_video.sv
// Scoreboard bench for stream_to_video on a reduced 24x6 raster (16x4 active).
module tb_stream_to_video;

    localparam int CT   = 24;
    localparam int CA   = 16;
    localparam int RT   = 6;
    localparam int RA   = 4;
    localparam int FPIX = CT * RT;

    logic       clk;
    logic       rst_i;
    logic       ce_i;
    logic [7:0] s_dat_i;
    logic       s_sof_i;
    logic       s_valid_i;
    logic       s_ready_o;
    logic       de_o;
    logic       pix_o;
    logic       frame_o;
    logic       underflow_o;

    stream_to_video #(
        .NumColTotal (10'd24),
        .NumColActive(10'd16),
        .NumRowTotal (10'd6),
        .NumRowActive(10'd4),
        .FifoDepth   (16)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .ce_i       (ce_i),
        .s_dat_i    (s_dat_i),
        .s_sof_i    (s_sof_i),
        .s_valid_i  (s_valid_i),
        .s_ready_o  (s_ready_o),
        .de_o       (de_o),
        .pix_o      (pix_o),
        .frame_o    (frame_o),
        .underflow_o(underflow_o)
    );

    int checks   = 0;
    int failures = 0;
    int accepted = 0;
    int mon_idx  = 0;
    logic mon_en = 1'b0;
    logic ce_q   = 1'b0;

    logic [8:0] pend [$];   // bytes waiting to be offered {sof, dat}
    logic [2:0] exp_q [$];  // expected {de, pix, frame} per ce cycle

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Queue nbytes of a frame image; the first byte optionally carries sof
    task automatic send_frame(input logic [63:0] data, input int nbytes, input logic first_sof);
        for (int i = 0; i < nbytes; i++) begin
            pend.push_back({(i == 0) && first_sof, data[63 - 8*i -: 8]});
        end
    endtask

    // Expected raster: pixel (r,c) is image bit r*CA+c counted from the MSB;
    // fetches from byte index 'good' onward render black
    task automatic exp_frame(input logic [63:0] data, input int good, input int nent);
        for (int k = 0; k < nent; k++) begin
            int r;
            int c;
            logic de;
            logic px;
            r  = k / CT;
            c  = k % CT;
            de = (c < CA) && (r < RA);
            px = 1'b0;
            if (de && ((r * (CA / 8) + c / 8) < good)) begin
                px = data[63 - (r * CA + c)];
            end
            exp_q.push_back({de, px, k == 0});
        end
    endtask

    // Issue n ce pulses, one every third clock, with the monitor armed
    task automatic run_ce(input int n);
        mon_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            ce_i = 1'b1;
            cycles(1);
            ce_i = 1'b0;
            cycles(2);
        end
        mon_en = 1'b0;
        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset(input int n);
        pend.delete();
        exp_q.delete();
        mon_en = 1'b0;
        ce_i   = 1'b0;
        rst_i  = 1'b1;
        cycles(n);
        chk("rst_de", 32'(de_o), 32'd0);
        chk("rst_pix", 32'(pix_o), 32'd0);
        chk("rst_frame", 32'(frame_o), 32'd0);
        chk("rst_underflow", 32'(underflow_o), 32'd0);
        chk("rst_ready", 32'(s_ready_o), 32'd0);
        rst_i = 1'b0;
        #1;
        chk("ready_after_release", 32'(s_ready_o), 32'd1);
        accepted = 0;
        @(posedge clk);
        #1;
    endtask

    // Feeder: offers the head of pend, retires it when accepted
    initial begin
        logic       acc;
        logic [8:0] tmp;
        s_valid_i = 1'b0;
        s_sof_i   = 1'b0;
        s_dat_i   = 8'h00;
        forever begin
            @(negedge clk);
            acc = s_valid_i && s_ready_o;
            @(posedge clk);
            if (acc && pend.size() > 0) begin
                tmp = pend.pop_front();
                accepted++;
            end
            #1;
            if (pend.size() > 0) begin
                s_valid_i          = 1'b1;
                {s_sof_i, s_dat_i} = pend[0];
            end else begin
                s_valid_i = 1'b0;
            end
        end
    end

    always @(posedge clk) ce_q <= ce_i;

    // Monitor: compares outputs after every ce edge against the scoreboard
    initial begin
        logic [2:0] e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (ce_q) begin
                    if (exp_q.size() == 0) begin
                        chk("exp_underrun", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("px%0d_de_pix_frame", mon_idx), 32'({de_o, pix_o, frame_o}), 32'(e));
                        mon_idx++;
                    end
                end else begin
                    chk("frame_pulse_width", 32'(frame_o), 32'd0);
                end
            end
        end
    end

    initial begin
        ce_i  = 1'b0;
        rst_i = 1'b1;

        // Backpressure: no ce, head has sof so SYNC never drains it
        do_reset(3);
        for (int i = 0; i < 20; i++) begin
            pend.push_back({i == 0, 8'(i)});
        end
        begin
            int t;
            t = 0;
            while (s_ready_o && t < 60) begin
                cycles(1);
                t++;
            end
            chk("bp_ready_fell", 32'(s_ready_o), 32'd0);
            chk("bp_accepted_at_fall", 32'(accepted), 32'd16);
        end
        cycles(5);
        chk("bp_ready_held", 32'(s_ready_o), 32'd0);
        chk("bp_accepted_held", 32'(accepted), 32'd16);
        chk("bp_pending", 32'(pend.size()), 32'd4);

        // Nominal: two back-to-back frames
        do_reset(2);
        send_frame(64'hA5A5_A5A5_A5A5_A5A5, 8, 1'b1);
        send_frame(64'h0123_4567_89AB_CDEF, 8, 1'b1);
        cycles(20);
        exp_frame(64'hA5A5_A5A5_A5A5_A5A5, 8, FPIX);
        exp_frame(64'h0123_4567_89AB_CDEF, 8, FPIX);
        run_ce(2 * FPIX);
        chk("nominal_underflow", 32'(underflow_o), 32'd0);

        // Leading garbage dropped in SYNC
        do_reset(2);
        send_frame(64'hFFFF_FFFF_FFFF_FFFF, 5, 1'b0);
        send_frame(64'h80C3_3C18_FF00_7E01, 8, 1'b1);
        cycles(30);
        exp_frame(64'h80C3_3C18_FF00_7E01, 8, FPIX);
        run_ce(FPIX);

        // Underflow after 5 bytes, then a clean frame
        do_reset(2);
        send_frame(64'hF0F0_F0F0_F0F0_F0F0, 5, 1'b1);
        cycles(20);
        exp_frame(64'hF0F0_F0F0_F0F0_F0F0, 5, FPIX);
        exp_frame(64'h1248_8421_55AA_C3E7, 8, FPIX);
        fork
            run_ce(2 * FPIX);
            begin
                int t;
                t = 0;
                while (!underflow_o && t < 400) begin
                    cycles(1);
                    t++;
                end
                chk("underflow_set", 32'(underflow_o), 32'd1);
                send_frame(64'h1248_8421_55AA_C3E7, 8, 1'b1);
            end
        join
        chk("underflow_sticky", 32'(underflow_o), 32'd1);

        // Early sof as byte 3, shown at the next frame start
        do_reset(2);
        send_frame(64'hFEDC_BA98_7654_3210, 3, 1'b1);
        send_frame(64'h9966_33CC_0FF0_A55A, 8, 1'b1);
        cycles(20);
        exp_frame(64'hFEDC_BA98_7654_3210, 3, FPIX);
        exp_frame(64'h9966_33CC_0FF0_A55A, 8, FPIX);
        run_ce(2 * FPIX);
        chk("early_sof_no_underflow", 32'(underflow_o), 32'd0);

        // Missing sof at frame start: that frame blanks, next sof frame shows
        do_reset(2);
        send_frame(64'h5A5A_1234_ABCD_EF01, 8, 1'b1);
        send_frame(64'hFFFF_FFFF_FFFF_FFFF, 8, 1'b0);
        send_frame(64'h8001_4002_2004_1008, 8, 1'b1);
        cycles(20);
        exp_frame(64'h5A5A_1234_ABCD_EF01, 8, FPIX);
        exp_frame(64'hFFFF_FFFF_FFFF_FFFF, 0, FPIX);
        exp_frame(64'h8001_4002_2004_1008, 8, FPIX);
        run_ce(3 * FPIX);
        chk("no_sof_no_underflow", 32'(underflow_o), 32'd0);

        // Mid-frame reset discards FIFO contents and the raster position
        do_reset(2);
        send_frame(64'hC0FF_EE00_1122_3344, 8, 1'b1);
        send_frame(64'hFFFF_FFFF_FFFF_FFFF, 8, 1'b1);
        cycles(20);
        exp_frame(64'hC0FF_EE00_1122_3344, 8, 2 * CT + 5);
        run_ce(2 * CT + 5);
        do_reset(2);
        send_frame(64'h7F3E_1D0C_8B4A_2960, 8, 1'b1);
        cycles(20);
        exp_frame(64'h7F3E_1D0C_8B4A_2960, 8, FPIX);
        run_ce(FPIX);
        chk("post_reset_underflow", 32'(underflow_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
